cnn_result_reader: RTL

Readback engine for the CNN_16 data memory, the read-side counterpart of the bench/host loader that writes the kernel, image and program words through the external sel/adr/data port. After a CONV completes, the block takes the external memory port. It reads a contiguous block of 16-bit result words (default: the 14x14 output feature map at 0x200) and streams them out on a valid/ready interface. It also keeps a running checksum for quick result comparison.

---
 rtl/cnn_result_reader.sv | 126 ++++++++++++
 1 files changed

// File: rtl/cnn_result_reader.sv
// CNN_16 result readback engine: owns the external memory port after a CONV,
// streams a block of result words on valid/ready and keeps a running checksum.
module cnn_result_reader #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 9
) (
    input  logic              clkn,
    input  logic              rstn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_adr,
    input  logic [LEN_W-1:0]  length,
    output logic              mem_sel,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_adr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic [LEN_W-1:0]  out_index,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_SEND,
        S_FINISH
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_base;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_idx;

    logic [LEN_W-1:0]  w_idx_nxt;
    logic [ADDR_W-1:0] w_adr_nxt;
    logic              w_last;
    logic              w_accept;

    // The reader never writes the data memory
    assign mem_we = 1'b0;

    // Next word offset/address; the address adder wraps at the top of memory
    assign w_idx_nxt = r_idx + LEN_W'(1);
    assign w_adr_nxt = r_base + ADDR_W'(w_idx_nxt);
    assign w_last    = (r_idx == r_len - LEN_W'(1));
    assign w_accept  = out_valid & out_ready;

    // Readback sequencer: address is set on entry to ISSUE, data captured a
    // cycle later, then held in SEND until the consumer takes it
    always_ff @(posedge clkn or posedge rstn) begin
        if (rstn) begin
            r_state   <= S_IDLE;
            r_base    <= '0;
            r_len     <= '0;
            r_idx     <= '0;
            mem_sel   <= 1'b0;
            mem_adr   <= '0;
            out_data  <= '0;
            out_index <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            checksum  <= '0;
        end else begin
            done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    // done is still high in the cycle after FINISH; a start
                    // that lands on it belongs to the finished run
                    if (start && !done) begin
                        r_base   <= base_adr;
                        r_len    <= length;
                        r_idx    <= '0;
                        checksum <= '0;
                        busy     <= 1'b1;
                        if (length == '0) begin
                            r_state <= S_FINISH;
                        end else begin
                            mem_sel <= 1'b1;
                            mem_adr <= base_adr;
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    out_data  <= mem_rdata;
                    out_index <= r_idx;
                    out_valid <= 1'b1;
                    r_state   <= S_SEND;
                end
                S_SEND: begin
                    if (w_accept) begin
                        out_valid <= 1'b0;
                        checksum  <= checksum + out_data;
                        if (w_last) begin
                            mem_sel <= 1'b0;
                            r_state <= S_FINISH;
                        end else begin
                            r_idx   <= w_idx_nxt;
                            mem_adr <= w_adr_nxt;
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_FINISH: begin
                    mem_sel <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
